// File: rtl/seq_detector_param.sv
// Serial pattern detector with an optional-overlap match, a prefix-progress
// indicator and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned              PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0]   PATTERN     = 4'b1011,
  parameter bit                       OVERLAP     = 1'b1,
  parameter int unsigned              COUNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_a_p,
  input  logic               enable,
  input  logic               din,
  input  logic               clear_cnt,
  output logic               match,
  output logic [3:0]         progress,
  output logic [COUNT_W-1:0] match_cnt,
  output logic               cnt_sat
);

  localparam int unsigned N      = PATTERN_LEN;
  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam int unsigned PROG_W = 4;

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(N);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  logic [N-1:0]       hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PROG_W-1:0]  prog_q, prog_d;
  logic               match_q, match_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [N-1:0]       hist_step;
  logic [FILL_W-1:0]  fill_step;
  logic               full_hit;
  logic [PROG_W-1:0]  best_full;
  logic [PROG_W-1:0]  best_prop;
  logic [N-1:0]       mask_k;
  logic [N-1:0]       pat_k;

  // Candidate history after consuming din, and the longest pattern prefix it ends with
  always_comb begin
    hist_step = {hist_q[N-2:0], din};
    fill_step = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    full_hit  = (fill_step == FILL_FULL) && (hist_step == PATTERN);
    best_full = '0;
    best_prop = '0;
    mask_k    = '0;
    pat_k     = '0;
    // Last k bits (oldest at bit k-1) against the first k pattern bits
    for (int k = 1; k <= int'(N); k++) begin
      mask_k = {N{1'b1}} >> (int'(N) - k);
      pat_k  = PATTERN >> (int'(N) - k);
      if ((hist_step & mask_k) == pat_k) begin
        if (k <= int'(fill_step)) best_full = PROG_W'(k);
        if (k < int'(N))          best_prop = PROG_W'(k);
      end
    end
  end

  // Next-state selection for history, fill, progress, pulse and counter
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    prog_d  = prog_q;
    match_d = 1'b0;
    if (enable) begin
      hist_d  = hist_step;
      match_d = full_hit;
      if (full_hit) begin
        // A hit restarts the prefix from the pattern's border, or from scratch
        fill_d = OVERLAP ? fill_step : '0;
        prog_d = OVERLAP ? best_prop : '0;
      end else begin
        fill_d = fill_step;
        prog_d = best_full;
      end
    end
    if (clear_cnt) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      hist_q  <= '0;
      fill_q  <= '0;
      prog_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      prog_q  <= prog_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign match     = match_q;
  assign progress  = prog_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param across overlap, counter-width and
// long-pattern configurations sharing one stimulus bus.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  int total = 0;
  int bad   = 0;

  logic       ov_match, nov_match, c2_match, n8_match;
  logic [3:0] ov_prog, nov_prog, c2_prog, n8_prog;
  logic [3:0] ov_cnt, nov_cnt, n8_cnt;
  logic [1:0] c2_cnt;
  logic       ov_sat, nov_sat, c2_sat, n8_sat;

  always #5 clk = ~clk;

  seq_detector_param u_ov (
    .clk(clk), .rst_a_p(rst), .enable(en), .din(din), .clear_cnt(clr),
    .match(ov_match), .progress(ov_prog), .match_cnt(ov_cnt), .cnt_sat(ov_sat));

  seq_detector_param #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst_a_p(rst), .enable(en), .din(din), .clear_cnt(clr),
    .match(nov_match), .progress(nov_prog), .match_cnt(nov_cnt), .cnt_sat(nov_sat));

  seq_detector_param #(.COUNT_W(2)) u_c2 (
    .clk(clk), .rst_a_p(rst), .enable(en), .din(din), .clear_cnt(clr),
    .match(c2_match), .progress(c2_prog), .match_cnt(c2_cnt), .cnt_sat(c2_sat));

  seq_detector_param #(.PATTERN_LEN(8), .PATTERN(8'b1111_1111)) u_n8 (
    .clk(clk), .rst_a_p(rst), .enable(en), .din(din), .clear_cnt(clr),
    .match(n8_match), .progress(n8_prog), .match_cnt(n8_cnt), .cnt_sat(n8_sat));

  // Single comparison point: counts and reports mismatches
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are stable 1ns after the edge
  task automatic step(input logic e, input logic d, input logic c);
    en  = e;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
  endtask

  int          stream7 [7]  = '{1, 0, 1, 1, 0, 1, 1};
  int          ov_p    [7]  = '{1, 2, 3, 1, 2, 3, 1};
  int          ov_m    [7]  = '{0, 0, 0, 1, 0, 0, 1};
  int          nov_p   [7]  = '{1, 2, 3, 0, 0, 1, 1};
  int          nov_m   [7]  = '{0, 0, 0, 1, 0, 0, 0};
  int          en_e    [8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
  int          en_d    [8]  = '{1, 1, 0, 0, 1, 0, 1, 1};
  int          en_m    [8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  int          en_p    [8]  = '{1, 1, 2, 2, 3, 3, 1, 1};
  int          c2_cnt_e[5]  = '{1, 2, 3, 3, 3};
  int          c2_sat_e[5]  = '{0, 0, 1, 1, 1};
  int          pat4    [4]  = '{1, 0, 1, 1};

  initial begin
    // Reset state
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_match", 32'(ov_match), 0);
    chk("rst_prog",  32'(ov_prog),  0);
    chk("rst_cnt",   32'(ov_cnt),   0);
    chk("rst_sat",   32'(ov_sat),   0);
    rst = 1'b0;

    // Overlapping and non-overlapping detection on the same stream
    for (int i = 0; i < 7; i++) begin
      step(1'b1, stream7[i][0], 1'b0);
      chk($sformatf("ov_prog%0d", i),   32'(ov_prog),   32'(ov_p[i]));
      chk($sformatf("ov_match%0d", i),  32'(ov_match),  32'(ov_m[i]));
      chk($sformatf("nov_prog%0d", i),  32'(nov_prog),  32'(nov_p[i]));
      chk($sformatf("nov_match%0d", i), 32'(nov_match), 32'(nov_m[i]));
    end
    chk("ov_cnt",  32'(ov_cnt),  2);
    chk("nov_cnt", 32'(nov_cnt), 1);

    // Plain counter clear with no step
    step(1'b0, 1'b0, 1'b1);
    chk("clr_cnt",   32'(ov_cnt),   0);
    chk("clr_prog",  32'(ov_prog),  1);
    chk("clr_match", 32'(ov_match), 0);

    // Reset mid-sequence discards the partial pattern
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_prog_pre", 32'(ov_prog), 3);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_prog_rst", 32'(ov_prog), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("mid_prog_post",  32'(ov_prog),  1);
    chk("mid_match_post", 32'(ov_match), 0);

    // Enable gating: garbage on disabled edges, single-cycle pulse
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(en_e[i][0], en_d[i][0], 1'b0);
      chk($sformatf("en_match%0d", i), 32'(ov_match), 32'(en_m[i]));
      chk($sformatf("en_prog%0d", i),  32'(ov_prog),  32'(en_p[i]));
    end
    chk("en_cnt", 32'(ov_cnt), 1);

    // Two-bit counter saturation, then clear coinciding with a detection
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 4; b++) step(1'b1, pat4[b][0], 1'b0);
      chk($sformatf("c2_match%0d", r), 32'(c2_match), 1);
      chk($sformatf("c2_cnt%0d", r),   32'(c2_cnt),   32'(c2_cnt_e[r]));
      chk($sformatf("c2_sat%0d", r),   32'(c2_sat),   32'(c2_sat_e[r]));
    end
    step(1'b1, 1'b1, 1'b0);
    chk("c2_hold_cnt", 32'(c2_cnt), 3);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("c2_clr_match", 32'(c2_match), 1);
    chk("c2_clr_cnt",   32'(c2_cnt),   0);
    chk("c2_clr_sat",   32'(c2_sat),   0);
    step(1'b0, 1'b0, 1'b0);
    chk("c2_after_match", 32'(c2_match), 0);

    // Eight-bit all-ones pattern with overlap
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk($sformatf("n8_match%0d", i), 32'(n8_match), (i >= 8) ? 1 : 0);
      chk($sformatf("n8_prog%0d", i),  32'(n8_prog),  (i >= 8) ? 7 : i);
    end
    chk("n8_cnt", 32'(n8_cnt), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
